// File: rtl/seq_shifter.sv
// seq_shifter: iterative one-bit-per-clock SLL/SRL/SRA shifter with start/busy/done handshake
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   op     in   00 SLL, 01 SRL, 10 SRA, 11 SRL
//   a      in   operand to shift
//   shamt  in   shift amount 0..n-1
//   result out  registered shifted value, updated on entry to DONE
//   busy   out  high whenever not idle
//   done   out  one-cycle completion pulse
module seq_shifter #(
  parameter int n  = 32,
  parameter int sw = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [n-1:0]  a,
  input  logic [sw-1:0] shamt,
  output logic [n-1:0]  result,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [sw-1:0] one = 1;
  state_t        r_state;
  logic [n-1:0]  r_acc;
  logic [sw-1:0] r_cnt;
  logic [1:0]    r_op;
  logic [n-1:0]  w_shifted;
  // SRA refills the top bit with the sign; SRL and the 11 encoding refill with zero
  assign w_shifted = (r_op == 2'b00) ? {r_acc[n-2:0], 1'b0}
                                     : {(r_op == 2'b10) & r_acc[n-1], r_acc[n-1:1]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_acc <= a;
            r_cnt <= shamt;
            r_op  <= op;
            busy  <= 1'b1;
            if (shamt == '0) begin
              result  <= a;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_acc <= w_shifted;
          r_cnt <= r_cnt - one;
          if (r_cnt == one) begin
            result  <= w_shifted;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
